reservation_station: RTL and testbench

//  Per-execution-unit reservation station; sits directly downstream of the decode stage (id).

---
 rtl/reservation_station_pkg.sv | 31 +++
 rtl/reservation_station_if.sv | 20 ++
 rtl/reservation_station_select.sv | 39 +++
 rtl/reservation_station.sv | 99 +++++++++
 tb/tb_reservation_station.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared widths and entry type; RS_AGE_PRIORITY_EN adds a per-entry age rank
`ifndef OP_TYPE_WIDTH
`define OP_TYPE_WIDTH 6
`endif
`ifndef INST_TAG_WIDTH
`define INST_TAG_WIDTH 5
`endif
`ifndef COMMON_LENGTH
`define COMMON_LENGTH 32
`endif
`ifndef EX_UNIT_NUM_WIDTH
`define EX_UNIT_NUM_WIDTH 2
`endif
package reservation_station_pkg;
  localparam int OP_W = `OP_TYPE_WIDTH;
  localparam int TAG_W = `INST_TAG_WIDTH;
  localparam int DATA_W = `COMMON_LENGTH;
  localparam int EXU_W = `EX_UNIT_NUM_WIDTH;
  localparam int RS_ENTRY_NUM = 4;
  localparam int ENTRY_IDX_W = $clog2(RS_ENTRY_NUM);
  typedef struct packed {
    logic valid;
    logic [OP_W-1:0] op;
    logic [1:2][TAG_W-1:0] tag;
    logic [1:2][DATA_W-1:0] val;
    logic [TAG_W-1:0] target;
`ifdef RS_AGE_PRIORITY_EN
    logic [ENTRY_IDX_W-1:0] age;
`endif
  } rs_entry_t;
endpackage

// File: rtl/reservation_station_if.sv
// reservation_station_if: dispatch, write-back broadcast and issue signals of a reservation station
interface reservation_station_if;
  import reservation_station_pkg::*;
  logic in_valid;
  logic [EXU_W-1:0] in_ex_unit;
  logic [OP_W-1:0] in_op, issue_op;
  logic [TAG_W-1:0] in_tag1, in_tag2, in_target, cdb_tag, issue_target;
  logic [DATA_W-1:0] in_val1, in_val2, cdb_val, issue_val1, issue_val2;
  logic full, cdb_valid, issue_valid, issue_ready;
  modport master (
    output in_valid, in_ex_unit, in_op, in_tag1, in_tag2, in_val1, in_val2, in_target,
    output cdb_valid, cdb_tag, cdb_val, issue_ready,
    input full, issue_valid, issue_op, issue_val1, issue_val2, issue_target
  );
  modport slave (
    input in_valid, in_ex_unit, in_op, in_tag1, in_tag2, in_val1, in_val2, in_target,
    input cdb_valid, cdb_tag, cdb_val, issue_ready,
    output full, issue_valid, issue_op, issue_val1, issue_val2, issue_target
  );
endinterface

// File: rtl/reservation_station_select.sv
// rs_select: picks one ready entry (lowest index, or smallest age rank with RS_AGE_PRIORITY_EN)
module rs_select #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input logic [N-1:0] ready,
`ifdef RS_AGE_PRIORITY_EN
  input logic [N-1:0][IW-1:0] age,
`endif
  output logic [N-1:0] gnt,
  output logic [IW-1:0] idx,
  output logic any
);
  logic found;
`ifdef RS_AGE_PRIORITY_EN
  logic [IW-1:0] best;
`endif
  always_comb begin
    idx = '0;
    found = 1'b0;
`ifdef RS_AGE_PRIORITY_EN
    best = '0;
    for (int i = 0; i < N; i++)
      if (ready[i] && (!found || age[i] < best)) begin
        idx = IW'(i);
        best = age[i];
        found = 1'b1;
      end
`else
    for (int i = 0; i < N; i++)
      if (ready[i] && !found) begin
        idx = IW'(i);
        found = 1'b1;
      end
`endif
  end
  assign any = |ready;
  assign gnt = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/reservation_station.sv
// reservation_station: per-unit operand-capture queue with CDB wakeup; RS_AGE_PRIORITY_EN issues oldest ready entry
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int UNIT_ID = 0,
  parameter int ENTRY_NUM = RS_ENTRY_NUM
) (
  input logic clk,
  input logic rst,
  input logic flush,
  reservation_station_if.slave bus
);
  localparam int IW = $clog2(ENTRY_NUM);
  rs_entry_t ent [ENTRY_NUM];
  rs_entry_t new_ent;
  logic [ENTRY_NUM-1:0] v, rdy, gnt;
  logic [IW-1:0] alloc_idx, sel_idx;
  logic any_rdy, accept, fire, cdb_hit, byp1, byp2;
`ifdef RS_AGE_PRIORITY_EN
  logic [ENTRY_NUM-1:0][IW-1:0] ages;
  logic [IW:0] occ;
`endif
  for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_ent
    assign v[g] = ent[g].valid;
    assign rdy[g] = ent[g].valid && ent[g].tag[1] == '0 && ent[g].tag[2] == '0;
`ifdef RS_AGE_PRIORITY_EN
    assign ages[g] = ent[g].age;
`endif
  end
  assign bus.full = &v;
  assign cdb_hit = bus.cdb_valid && bus.cdb_tag != '0;
  assign accept = bus.in_valid && bus.in_ex_unit == EXU_W'(UNIT_ID) && bus.in_target != '0 && !(&v);
  assign fire = any_rdy && bus.issue_ready;
  assign byp1 = cdb_hit && bus.in_tag1 == bus.cdb_tag;
  assign byp2 = cdb_hit && bus.in_tag2 == bus.cdb_tag;
  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--)
      if (!v[i]) alloc_idx = IW'(i);
  end
`ifdef RS_AGE_PRIORITY_EN
  always_comb begin
    occ = '0;
    for (int i = 0; i < ENTRY_NUM; i++)
      occ = occ + (IW+1)'(v[i]);
  end
`endif
  always_comb begin
    new_ent = '0;
    new_ent.valid = 1'b1;
    new_ent.op = bus.in_op;
    new_ent.tag[1] = byp1 ? '0 : bus.in_tag1;
    new_ent.tag[2] = byp2 ? '0 : bus.in_tag2;
    new_ent.val[1] = byp1 ? bus.cdb_val : bus.in_val1;
    new_ent.val[2] = byp2 ? bus.cdb_val : bus.in_val2;
    new_ent.target = bus.in_target;
`ifdef RS_AGE_PRIORITY_EN
    new_ent.age = IW'(occ - (IW+1)'(fire));
`endif
  end
  rs_select #(.N(ENTRY_NUM), .IW(IW)) u_sel (
    .ready(rdy),
`ifdef RS_AGE_PRIORITY_EN
    .age(ages),
`endif
    .gnt(gnt),
    .idx(sel_idx),
    .any(any_rdy)
  );
  assign bus.issue_valid = any_rdy;
  assign bus.issue_op = any_rdy ? ent[sel_idx].op : '0;
  assign bus.issue_val1 = any_rdy ? ent[sel_idx].val[1] : '0;
  assign bus.issue_val2 = any_rdy ? ent[sel_idx].val[2] : '0;
  assign bus.issue_target = any_rdy ? ent[sel_idx].target : '0;
  // the allocated slot is always a free one, so it never collides with the issuing entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) ent[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRY_NUM; i++) ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (cdb_hit && ent[i].tag[1] == bus.cdb_tag) begin
          ent[i].tag[1] <= '0;
          ent[i].val[1] <= bus.cdb_val;
        end
        if (cdb_hit && ent[i].tag[2] == bus.cdb_tag) begin
          ent[i].tag[2] <= '0;
          ent[i].val[2] <= bus.cdb_val;
        end
        if (fire && gnt[i]) ent[i].valid <= 1'b0;
`ifdef RS_AGE_PRIORITY_EN
        if (fire && ent[i].valid && ent[i].age > ent[sel_idx].age) ent[i].age <= ent[i].age - 1'b1;
`endif
        if (accept && alloc_idx == IW'(i)) ent[i] <= new_ent;
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios plus randomized traffic against an allocation-order model
module tb_reservation_station;
  import reservation_station_pkg::*;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;
  reservation_station_if bus();
  reservation_station #(.UNIT_ID(0), .ENTRY_NUM(RS_ENTRY_NUM)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus)
  );
  typedef struct {
    bit v;
    int op, t1, t2, v1, v2, tgt, seq;
  } m_t;
  m_t m [RS_ENTRY_NUM];
  int seq_n = 0;
  int n_vec = 0, n_err = 0;
  // oldest instruction is the one with the smallest allocation sequence number
  function automatic int m_sel();
    int s = -1;
    for (int i = 0; i < RS_ENTRY_NUM; i++)
      if (m[i].v && m[i].t1 == 0 && m[i].t2 == 0) begin
`ifdef RS_AGE_PRIORITY_EN
        if (s < 0 || m[i].seq < m[s].seq) s = i;
`else
        if (s < 0) s = i;
`endif
      end
    return s;
  endfunction
  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < RS_ENTRY_NUM; i++) f &= m[i].v;
    return f;
  endfunction
  task automatic model_update();
    int sel, slot, ct;
    bit fire, full;
    if (!rst || flush) begin
      for (int i = 0; i < RS_ENTRY_NUM; i++) m[i].v = 1'b0;
    end else begin
      sel = m_sel();
      full = m_full();
      fire = sel >= 0 && bus.issue_ready;
      slot = -1;
      for (int i = RS_ENTRY_NUM - 1; i >= 0; i--) if (!m[i].v) slot = i;
      ct = bus.cdb_valid ? int'(bus.cdb_tag) : 0;
      for (int i = 0; i < RS_ENTRY_NUM; i++)
        if (m[i].v && ct != 0) begin
          if (m[i].t1 == ct) begin m[i].t1 = 0; m[i].v1 = int'(bus.cdb_val); end
          if (m[i].t2 == ct) begin m[i].t2 = 0; m[i].v2 = int'(bus.cdb_val); end
        end
      if (fire) m[sel].v = 1'b0;
      if (bus.in_valid && bus.in_ex_unit == 0 && bus.in_target != 0 && !full) begin
        m[slot].v = 1'b1;
        m[slot].op = int'(bus.in_op);
        m[slot].tgt = int'(bus.in_target);
        m[slot].seq = seq_n++;
        m[slot].t1 = (ct != 0 && int'(bus.in_tag1) == ct) ? 0 : int'(bus.in_tag1);
        m[slot].v1 = (ct != 0 && int'(bus.in_tag1) == ct) ? int'(bus.cdb_val) : int'(bus.in_val1);
        m[slot].t2 = (ct != 0 && int'(bus.in_tag2) == ct) ? 0 : int'(bus.in_tag2);
        m[slot].v2 = (ct != 0 && int'(bus.in_tag2) == ct) ? int'(bus.cdb_val) : int'(bus.in_val2);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic drive(bit vld, int unit, int op, int t1, int t2, int v1, int v2, int tgt);
    bus.in_valid = vld;
    bus.in_ex_unit = EXU_W'(unit);
    bus.in_op = OP_W'(op);
    bus.in_tag1 = TAG_W'(t1);
    bus.in_tag2 = TAG_W'(t2);
    bus.in_val1 = DATA_W'(v1);
    bus.in_val2 = DATA_W'(v2);
    bus.in_target = TAG_W'(tgt);
  endtask
  task automatic cdb(bit vld, int t, int d);
    bus.cdb_valid = vld;
    bus.cdb_tag = TAG_W'(t);
    bus.cdb_val = DATA_W'(d);
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cdb(0, 0, 0);
  endtask
  task automatic test_reset();
    rst = 1'b0;
    drive(1, 0, 5, 0, 0, 1, 2, 3);
    cdb(0, 0, 0);
    bus.issue_ready = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", bus.full); end
    n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_issue_valid got %b want 0", bus.issue_valid); end
    n_vec++;
    if ({bus.issue_op, bus.issue_val1, bus.issue_val2, bus.issue_target} !== '0) begin
      n_err++;
      $display("FAIL reset_issue_fields got op=%h v1=%h v2=%h tgt=%h want all 0", bus.issue_op, bus.issue_val1, bus.issue_val2, bus.issue_target);
    end
    rst = 1'b1;
    idle();
    tick();
  endtask
  task automatic test_ready_dispatch();
    bus.issue_ready = 1'b1;
    drive(1, 0, 5, 0, 0, 'h11, 'h22, 3);
    tick();
    idle();
    n_vec++; if (bus.issue_valid !== 1'b1) begin n_err++; $display("FAIL dispatch_valid got %b want 1", bus.issue_valid); end
    n_vec++;
    if ({bus.issue_op, bus.issue_val1, bus.issue_val2, bus.issue_target} !== {OP_W'(5), DATA_W'('h11), DATA_W'('h22), TAG_W'(3)}) begin
      n_err++;
      $display("FAIL dispatch_fields got op=%0d v1=%h v2=%h tgt=%0d want 5/11/22/3", bus.issue_op, bus.issue_val1, bus.issue_val2, bus.issue_target);
    end
    tick();
    n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL dispatch_drain got %b want 0", bus.issue_valid); end
  endtask
  task automatic test_wakeup();
    bus.issue_ready = 1'b1;
    drive(1, 0, 2, 7, 0, 0, 'h5, 4);
    tick();
    idle();
    n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL wake_wait1 got %b want 0", bus.issue_valid); end
    tick();
    n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL wake_wait2 got %b want 0", bus.issue_valid); end
    cdb(1, 7, 'hAB);
    tick();
    cdb(0, 0, 0);
    n_vec++;
    if ({bus.issue_valid, bus.issue_val1, bus.issue_val2, bus.issue_target} !== {1'b1, DATA_W'('hAB), DATA_W'(5), TAG_W'(4)}) begin
      n_err++;
      $display("FAIL wake_issue got v=%b v1=%h v2=%h tgt=%0d want 1/ab/5/4", bus.issue_valid, bus.issue_val1, bus.issue_val2, bus.issue_target);
    end
    tick();
    drive(1, 0, 3, 7, 0, 0, 'h6, 5);
    cdb(1, 7, 'hCD);
    tick();
    idle();
    n_vec++;
    if ({bus.issue_valid, bus.issue_val1, bus.issue_target} !== {1'b1, DATA_W'('hCD), TAG_W'(5)}) begin
      n_err++;
      $display("FAIL wake_bypass got v=%b v1=%h tgt=%0d want 1/cd/5", bus.issue_valid, bus.issue_val1, bus.issue_target);
    end
    tick();
    drive(1, 0, 1, 9, 9, 0, 0, 6);
    tick();
    idle();
    cdb(1, 9, 'hEE);
    tick();
    cdb(0, 0, 0);
    n_vec++;
    if ({bus.issue_valid, bus.issue_val1, bus.issue_val2} !== {1'b1, DATA_W'('hEE), DATA_W'('hEE)}) begin
      n_err++;
      $display("FAIL wake_both got v=%b v1=%h v2=%h want 1/ee/ee", bus.issue_valid, bus.issue_val1, bus.issue_val2);
    end
    tick();
    n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL wake_drain got %b want 0", bus.issue_valid); end
  endtask
  task automatic test_full();
    bus.issue_ready = 1'b0;
    for (int i = 0; i < RS_ENTRY_NUM; i++) begin
      drive(1, 0, i + 1, 0, 0, i, i, i + 1);
      tick();
    end
    n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL full_set got %b want 1", bus.full); end
    drive(1, 0, 9, 0, 0, 9, 9, 9);
    tick();
    n_vec++;
    if ({bus.full, bus.issue_target} !== {1'b1, TAG_W'(1)}) begin
      n_err++;
      $display("FAIL full_ignore got full=%b tgt=%0d want 1/1", bus.full, bus.issue_target);
    end
    bus.issue_ready = 1'b1;
    drive(1, 0, 10, 0, 0, 10, 10, 10);
    #2;
    n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL full_same_cycle got %b want 1", bus.full); end
    tick();
    idle();
    n_vec++;
    if ({bus.full, bus.issue_target} !== {1'b0, TAG_W'(2)}) begin
      n_err++;
      $display("FAIL full_release got full=%b tgt=%0d want 0/2", bus.full, bus.issue_target);
    end
    for (int t = 3; t <= RS_ENTRY_NUM + 1; t++) begin
      tick();
      n_vec++;
      if (t <= RS_ENTRY_NUM ? bus.issue_target !== TAG_W'(t) : bus.issue_valid !== 1'b0) begin
        n_err++;
        $display("FAIL full_drain step %0d got v=%b tgt=%0d", t, bus.issue_valid, bus.issue_target);
      end
    end
  endtask
  task automatic test_unit_filter();
    bus.issue_ready = 1'b0;
    drive(1, 1, 4, 0, 0, 1, 1, 5);
    tick();
    drive(1, 0, 4, 0, 0, 1, 1, 0);
    tick();
    idle();
    n_vec++;
    if ({bus.full, bus.issue_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL unit_filter got full=%b valid=%b want 0/0", bus.full, bus.issue_valid);
    end
  endtask
  task automatic test_priority();
    int exp_first, exp_second;
    bus.issue_ready = 1'b0;
    for (int i = 0; i < RS_ENTRY_NUM; i++) begin
      drive(1, 0, i, 11 + i, 0, 0, 0, i + 1);
      tick();
    end
    idle();
    cdb(1, 14, 'h44);
    tick();
    cdb(1, 11, 'h41);
    tick();
    cdb(0, 0, 0);
    n_vec++;
    if ({bus.issue_target, bus.issue_val1} !== {TAG_W'(1), DATA_W'('h41)}) begin
      n_err++;
      $display("FAIL prio_first got tgt=%0d v1=%h want 1/41", bus.issue_target, bus.issue_val1);
    end
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    n_vec++;
    if ({bus.issue_target, bus.issue_val1} !== {TAG_W'(4), DATA_W'('h44)}) begin
      n_err++;
      $display("FAIL prio_second got tgt=%0d v1=%h want 4/44", bus.issue_target, bus.issue_val1);
    end
    flush = 1'b1;
    drive(1, 0, 1, 0, 0, 0, 0, 7);
    tick();
    flush = 1'b0;
    idle();
    n_vec++;
    if ({bus.full, bus.issue_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_clear got full=%b valid=%b want 0/0", bus.full, bus.issue_valid);
    end
    drive(1, 0, 1, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 2, 22, 0, 0, 0, 2);
    tick();
    idle();
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    drive(1, 0, 3, 23, 0, 0, 0, 3);
    tick();
    idle();
    cdb(1, 23, 'h33);
    tick();
    cdb(1, 22, 'h22);
    tick();
    cdb(0, 0, 0);
`ifdef RS_AGE_PRIORITY_EN
    exp_first = 2; exp_second = 3;
`else
    exp_first = 3; exp_second = 2;
`endif
    n_vec++;
    if (bus.issue_target !== TAG_W'(exp_first)) begin
      n_err++;
      $display("FAIL prio_policy_first got tgt=%0d want %0d", bus.issue_target, exp_first);
    end
    bus.issue_ready = 1'b1;
    tick();
    n_vec++;
    if (bus.issue_target !== TAG_W'(exp_second)) begin
      n_err++;
      $display("FAIL prio_policy_second got tgt=%0d want %0d", bus.issue_target, exp_second);
    end
    tick();
  endtask
  task automatic test_random();
    int sel;
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 3) != 0, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0, $urandom_range(0, 63),
            $urandom_range(0, 1) ? 0 : $urandom_range(1, 4), $urandom_range(0, 1) ? 0 : $urandom_range(1, 4),
            $urandom, $urandom, $urandom_range(0, 31));
      cdb($urandom_range(0, 1), $urandom_range(0, 4), $urandom);
      bus.issue_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 59) == 0;
      tick();
      sel = m_sel();
      n_vec++; if (bus.full !== m_full()) begin n_err++; $display("FAIL rnd_full cyc %0d got %b want %b", c, bus.full, m_full()); end
      n_vec++; if (bus.issue_valid !== (sel >= 0)) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, bus.issue_valid, sel >= 0); end
      n_vec++;
      if (bus.issue_op !== OP_W'(sel >= 0 ? m[sel].op : 0)) begin
        n_err++; $display("FAIL rnd_op cyc %0d got %0d want %0d", c, bus.issue_op, sel >= 0 ? m[sel].op : 0);
      end
      n_vec++;
      if (bus.issue_val1 !== DATA_W'(sel >= 0 ? m[sel].v1 : 0)) begin
        n_err++; $display("FAIL rnd_val1 cyc %0d got %h want %h", c, bus.issue_val1, sel >= 0 ? m[sel].v1 : 0);
      end
      n_vec++;
      if (bus.issue_val2 !== DATA_W'(sel >= 0 ? m[sel].v2 : 0)) begin
        n_err++; $display("FAIL rnd_val2 cyc %0d got %h want %h", c, bus.issue_val2, sel >= 0 ? m[sel].v2 : 0);
      end
      n_vec++;
      if (bus.issue_target !== TAG_W'(sel >= 0 ? m[sel].tgt : 0)) begin
        n_err++; $display("FAIL rnd_target cyc %0d got %0d want %0d", c, bus.issue_target, sel >= 0 ? m[sel].tgt : 0);
      end
    end
    flush = 1'b0;
    idle();
  endtask
  initial begin
    idle();
    bus.issue_ready = 1'b0;
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_full();
    test_unit_filter();
    test_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
